// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration controller:
// FSM states, frame geometry and register addresses.
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_e;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    // Bit positions inside a received frame (MSB first on the wire)
    localparam int RW_BIT  = 15;
    localparam int ADDR_HI = 14;
    localparam int ADDR_LO = 8;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_PWM_DUTY  = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous pin followed by a
// single-flop edge detector; reset value is chosen per pin.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI mode-0 write-only configuration port: synchronizes the SPI pins,
// assembles 16-bit frames and commits validated writes to the register bank.
module spi_cfg_ctrl
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_out_7_0,
    output logic [7:0] en_out_15_8,
    output logic [7:0] en_pwm_7_0,
    output logic [7:0] en_pwm_15_8,
    output logic [7:0] pwm_duty,
    output logic       wr_stb,
    output logic       frame_err
);

    logic sclk_rise, sclk_lvl_unused, sclk_fall_unused;
    logic copi_lvl, copi_rise_unused, copi_fall_unused;
    logic ncs_rise, ncs_fall, ncs_lvl_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .level (sclk_lvl_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (copi),
        .level (copi_lvl),
        .rise  (copi_rise_unused),
        .fall  (copi_fall_unused)
    );

    // nCS resets low so a frame already running at reset release yields no fall
    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ncs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ncs),
        .level (ncs_lvl_unused),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    cfg_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]       shreg_q, shreg_d;
    logic                        ovf_q, ovf_d;
    logic                        pend_q, pend_d;
    logic                        wr_stb_q, wr_stb_d;
    logic                        frame_err_q, frame_err_d;
    logic [DATA_W-1:0]           regs_q [NUM_REGS];
    logic [DATA_W-1:0]           regs_d [NUM_REGS];

    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              frame_rw;
    logic              frame_full;
    logic              addr_ok;
    logic              accept;

    assign frame_addr = shreg_q[ADDR_HI:ADDR_LO];
    assign frame_data = shreg_q[DATA_HI:DATA_LO];
    assign frame_rw   = shreg_q[RW_BIT];
    assign frame_full = (cnt_q == CNT_W'(FRAME_BITS)) && !ovf_q;
    assign addr_ok    = 32'(frame_addr) < 32'(NUM_REGS);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ovf_d       = ovf_q;
        pend_d      = pend_q;
        wr_stb_d    = 1'b0;
        frame_err_d = 1'b0;
        accept      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (ncs_fall || pend_q) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A coincident SCLK edge lands in cnt/shreg before COMMIT looks at them
                if (sclk_rise) begin
                    if (cnt_q < CNT_W'(FRAME_BITS)) begin
                        shreg_d = {shreg_q[FRAME_BITS-2:0], copi_lvl};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (ncs_fall) begin
                    pend_d = 1'b1;
                end
                if (frame_full && frame_rw && addr_ok) begin
                    accept = 1'b1;
                end else if (!(frame_full && !frame_rw)) begin
                    frame_err_d = 1'b1;
                end
                wr_stb_d = accept;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (accept && (frame_addr == ADDR_W'(i))) begin
                regs_d[i] = frame_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            wr_stb_q    <= wr_stb_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign en_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign en_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign en_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
    assign en_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty    = regs_q[ADDR_PWM_DUTY];
    assign wr_stb      = wr_stb_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Bench for spi_cfg_ctrl: directed and random SPI frames at SCLK = clk/10,
// checked against a frame-level model of the register bank and pulse counts.
module tb_spi_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, copi, ncs;
    logic [7:0] en_out_7_0, en_out_15_8, en_pwm_7_0, en_pwm_15_8, pwm_duty;
    logic       wr_stb, frame_err;

    spi_cfg_ctrl #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .copi        (copi),
        .ncs         (ncs),
        .en_out_7_0  (en_out_7_0),
        .en_out_15_8 (en_out_15_8),
        .en_pwm_7_0  (en_pwm_7_0),
        .en_pwm_15_8 (en_pwm_15_8),
        .pwm_duty    (pwm_duty),
        .wr_stb      (wr_stb),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int stb_cnt  = 0;
    int err_cnt  = 0;
    logic [7:0] model_regs [5];

    always @(negedge clk) begin
        if (wr_stb)    stb_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".en_out_lo"}, 32'(en_out_7_0),  32'(model_regs[0]));
        chk({tag, ".en_out_hi"}, 32'(en_out_15_8), 32'(model_regs[1]));
        chk({tag, ".en_pwm_lo"}, 32'(en_pwm_7_0),  32'(model_regs[2]));
        chk({tag, ".en_pwm_hi"}, 32'(en_pwm_15_8), 32'(model_regs[3]));
        chk({tag, ".pwm_duty"},  32'(pwm_duty),    32'(model_regs[4]));
    endtask

    task automatic start_frame();
        @(negedge clk);
        ncs = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Bits at index >= 16 are filler for over-long frames
    task automatic send_bits(input logic [15:0] w, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            copi = (i < 16) ? w[15 - i] : 1'($urandom_range(0, 1));
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Raises nCS and returns the clk edge count at which the first pulse shows
    task automatic end_frame(output int lat);
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        lat = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if ((wr_stb || frame_err) && lat == 0) lat = e;
        end
        repeat (2) @(negedge clk);
    endtask

    // Frame-level reference: returns expected pulses and updates the model bank
    task automatic model_frame(input logic [15:0] w, input int nbits,
                               output int exp_stb, output int exp_err);
        exp_stb = 0;
        exp_err = 0;
        if (nbits != 16) begin
            exp_err = 1;
        end else if (w[15]) begin
            if (int'(w[14:8]) < 5) begin
                model_regs[int'(w[14:8])] = w[7:0];
                exp_stb = 1;
            end else begin
                exp_err = 1;
            end
        end
    endtask

    task automatic do_frame(input string tag, input logic [15:0] w, input int nbits);
        int s0, e0, lat, xs, xe;
        s0 = stb_cnt;
        e0 = err_cnt;
        start_frame();
        send_bits(w, 0, nbits);
        end_frame(lat);
        model_frame(w, nbits, xs, xe);
        chk({tag, ".wr_stb_pulses"}, 32'(stb_cnt - s0), 32'(xs));
        chk({tag, ".frame_err_pulses"}, 32'(err_cnt - e0), 32'(xe));
        if (xs + xe > 0)
            chk({tag, ".pulse_latency_3to4"}, 32'(lat >= 3 && lat <= 4), 32'd1);
        check_regs(tag);
    endtask

    initial begin
        int s0, e0, lat, kind, n;
        logic [15:0] w;

        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset.wr_stb", 32'(wr_stb), 32'd0);
        chk("reset.frame_err", 32'(frame_err), 32'd0);
        check_regs("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_regs("post_reset");

        do_frame("wr_duty", 16'h8480, 16);
        do_frame("wr_addr5", 16'h85AA, 16);
        do_frame("short12", 16'h8133, 12);
        do_frame("long17", 16'h8133, 17);
        do_frame("read0", 16'h0055, 16);

        // Reset in mid-frame: the rest of the frame must not write anything
        do_frame("wr_pre", 16'h8033, 16);
        s0 = stb_cnt;
        e0 = err_cnt;
        start_frame();
        send_bits(16'h81FF, 0, 10);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_bits(16'h81FF, 10, 16);
        end_frame(lat);
        chk("rst_mid.wr_stb_pulses", 32'(stb_cnt - s0), 32'd0);
        chk("rst_mid.frame_err_pulses", 32'(err_cnt - e0), 32'd0);
        check_regs("rst_mid");
        do_frame("wr_after_rst", 16'h81FF, 16);

        // Back-to-back with one clk of nCS high between frames
        s0 = stb_cnt;
        e0 = err_cnt;
        start_frame();
        send_bits(16'h800F, 0, 16);
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        @(negedge clk);
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        send_bits(16'h82F0, 0, 16);
        end_frame(lat);
        model_regs[0] = 8'h0F;
        model_regs[2] = 8'hF0;
        chk("b2b.wr_stb_pulses", 32'(stb_cnt - s0), 32'd2);
        chk("b2b.frame_err_pulses", 32'(err_cnt - e0), 32'd0);
        check_regs("b2b");

        for (int f = 0; f < 24; f++) begin
            kind = int'($urandom_range(0, 4));
            n = 16;
            case (kind)
                0: w = {1'b1, 7'($urandom_range(0, 4)), 8'($urandom)};
                1: w = {1'b1, 7'($urandom_range(5, 127)), 8'($urandom)};
                2: w = {1'b0, 7'($urandom_range(0, 4)), 8'($urandom)};
                3: begin
                    w = {1'b1, 7'($urandom_range(0, 4)), 8'($urandom)};
                    n = int'($urandom_range(1, 15));
                end
                default: begin
                    w = {1'b1, 7'($urandom_range(0, 4)), 8'($urandom)};
                    n = int'($urandom_range(17, 20));
                end
            endcase
            do_frame($sformatf("rnd%0d_k%0d", f, kind), w, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
